// File: rtl/bank_pkg.sv
// ---------------------------------------------------------------------------
// bank_pkg
//   Shared definitions for the Bank initiator logic: controller state
//   encoding, default array geometry and default DRAM-style timing.
//   No ports (package).
// ---------------------------------------------------------------------------
package bank_pkg;

  // Default geometry of one Bank
  localparam int DEVICE_WIDTH_DEF = 4;
  localparam int COLWIDTH_DEF     = 10;
  localparam int CHWIDTH_DEF      = 5;
  localparam int BLWIDTH_DEF      = 4;

  // Default timing, in clock cycles
  localparam int T_RCD_DEF  = 3;
  localparam int T_RP_DEF   = 3;
  localparam int RD_LAT_DEF = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    ACT   = 2'd2,
    BURST = 2'd3
  } state_t;

endpackage

// File: rtl/bank_rd_pipe.sv
// ---------------------------------------------------------------------------
// bank_rd_pipe
//   Read-return tracker. Shifts a "column read issued" flag through LAT
//   stages so that a beat is flagged exactly LAT cycles after the column
//   appeared on the Bank pins. The Bank delivers dqout aligned to that same
//   cycle, so the data path is a gate that presents dqout only while a
//   tracked beat is present (zero otherwise).
// Ports
//   clk      in   clock
//   i_flush  in   synchronous clear of all in-flight beats
//   i_issue  in   a read column is on the Bank pins this cycle
//   i_dqout  in   Bank read data
//   o_valid  out  read beat present
//   o_data   out  read beat data (zero when o_valid is low)
// ---------------------------------------------------------------------------
module bank_rd_pipe #(
  parameter int DW  = 4,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          i_flush,
  input  logic          i_issue,
  input  logic [DW-1:0] i_dqout,
  output logic          o_valid,
  output logic [DW-1:0] o_data
);

  logic [LAT-1:0] r_vld;
  logic [LAT-1:0] w_vld_in;

  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign w_vld_in[gi] = i_issue;
      end else begin : g_tail
        assign w_vld_in[gi] = r_vld[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (i_flush) r_vld <= '0;
    else         r_vld <= w_vld_in;
  end

  assign o_valid = r_vld[LAT-1];
  assign o_data  = o_valid ? i_dqout : '0;

endmodule

// File: rtl/bank_access_ctrl.sv
// ---------------------------------------------------------------------------
// bank_access_ctrl
//   Initiator for one Bank. Takes burst read/write requests, keeps one row
//   open between bursts (open-page), precharges/activates on a row miss,
//   streams write beats into the Bank and returns read beats RD_LAT cycles
//   after each read column is issued. All Bank-facing outputs are registered.
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   req_valid/req_ready              request handshake (ready only in IDLE)
//   req_wr, req_row, req_col, req_len  burst descriptor (len = beats-1)
//   wdata_valid/wdata_ready, wdata   write beat stream
//   rdata_valid, rdata               read beat stream (no backpressure)
//   rd_o_wr, row, column, dqin       Bank command/address/write data
//   dqout                            Bank read data
// ---------------------------------------------------------------------------
module bank_access_ctrl
  import bank_pkg::*;
#(
  parameter int DEVICE_WIDTH = DEVICE_WIDTH_DEF,
  parameter int COLWIDTH     = COLWIDTH_DEF,
  parameter int CHWIDTH      = CHWIDTH_DEF,
  parameter int BLWIDTH      = BLWIDTH_DEF,
  parameter int T_RCD        = T_RCD_DEF,
  parameter int T_RP         = T_RP_DEF,
  parameter int RD_LAT       = RD_LAT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wr,
  input  logic [CHWIDTH-1:0]      req_row,
  input  logic [COLWIDTH-1:0]     req_col,
  input  logic [BLWIDTH-1:0]      req_len,
  input  logic                    wdata_valid,
  output logic                    wdata_ready,
  input  logic [DEVICE_WIDTH-1:0] wdata,
  output logic                    rdata_valid,
  output logic [DEVICE_WIDTH-1:0] rdata,
  output logic                    rd_o_wr,
  output logic [CHWIDTH-1:0]      row,
  output logic [COLWIDTH-1:0]     column,
  output logic [DEVICE_WIDTH-1:0] dqin,
  input  logic [DEVICE_WIDTH-1:0] dqout
);

  localparam int DLY_MAX = (T_RP > T_RCD) ? T_RP : T_RCD;
  localparam int DLY_W   = $clog2(DLY_MAX + 1);

  state_t r_state, w_state_next;

  // Latched request
  logic                    r_wr;
  logic [CHWIDTH-1:0]      r_req_row;
  logic [COLWIDTH-1:0]     r_col;
  logic [BLWIDTH-1:0]      r_len;
  logic [BLWIDTH-1:0]      r_beat;

  // Open-page bookkeeping
  logic                    r_row_open;
  logic [CHWIDTH-1:0]      r_open_row;
  logic [DLY_W-1:0]        r_dly;

  // Registered Bank pins
  logic                    r_rd_o_wr;
  logic [CHWIDTH-1:0]      r_row;
  logic [COLWIDTH-1:0]     r_column;
  logic [DEVICE_WIDTH-1:0] r_dqin;
  logic                    r_rd_issue;

  logic w_accept, w_hit, w_dly_done, w_beat, w_last;

  assign w_accept   = req_valid && req_ready;
  assign w_hit      = r_row_open && (r_open_row == req_row);
  assign w_dly_done = (r_dly == '0);
  // Reads issue every BURST cycle; writes only when a beat is offered
  assign w_beat     = (r_state == BURST) && (!r_wr || wdata_valid);
  assign w_last     = w_beat && (r_beat == r_len);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_hit)           w_state_next = BURST;
          else if (r_row_open) w_state_next = PRE;
          else                 w_state_next = ACT;
        end
      end
      PRE:     if (w_dly_done) w_state_next = ACT;
      ACT:     if (w_dly_done) w_state_next = BURST;
      BURST:   if (w_last)     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    req_ready   = (r_state == IDLE) && !rst;
    wdata_ready = (r_state == BURST) && r_wr;
  end

  // Request latch, delay/beat/column counters and Bank pin registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr       <= 1'b0;
      r_req_row  <= '0;
      r_col      <= '0;
      r_len      <= '0;
      r_beat     <= '0;
      r_row_open <= 1'b0;
      r_open_row <= '0;
      r_dly      <= '0;
      r_rd_o_wr  <= 1'b0;
      r_row      <= '0;
      r_column   <= '0;
      r_dqin     <= '0;
      r_rd_issue <= 1'b0;
    end else begin
      r_rd_o_wr  <= 1'b0;
      r_dqin     <= '0;
      r_rd_issue <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_wr      <= req_wr;
            r_req_row <= req_row;
            r_col     <= req_col;
            r_len     <= req_len;
            r_beat    <= '0;
            // Preload whichever wait comes first: precharge on a conflict,
            // activate when no row is open (unused on a hit)
            r_dly     <= r_row_open ? DLY_W'(T_RP - 1) : DLY_W'(T_RCD - 1);
          end
        end
        PRE: begin
          if (w_dly_done) begin
            r_row_open <= 1'b0;
            r_dly      <= DLY_W'(T_RCD - 1);
          end else begin
            r_dly <= r_dly - 1'b1;
          end
        end
        ACT: begin
          r_row <= r_req_row;
          if (w_dly_done) begin
            r_row_open <= 1'b1;
            r_open_row <= r_req_row;
          end else begin
            r_dly <= r_dly - 1'b1;
          end
        end
        BURST: begin
          if (w_beat) begin
            r_rd_o_wr  <= r_wr;
            r_dqin     <= r_wr ? wdata : '0;
            r_column   <= r_col;
            r_col      <= r_col + 1'b1;   // wraps within the row
            r_beat     <= r_beat + 1'b1;
            r_rd_issue <= !r_wr;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_o_wr = r_rd_o_wr;
  assign row     = r_row;
  assign column  = r_column;
  assign dqin    = r_dqin;

  // Read returns drain independently of the FSM so the next burst can
  // start while earlier data is still coming back
  bank_rd_pipe #(
    .DW  (DEVICE_WIDTH),
    .LAT (RD_LAT)
  ) u_rd_pipe (
    .clk     (clk),
    .i_flush (rst),
    .i_issue (r_rd_issue),
    .i_dqout (dqout),
    .o_valid (rdata_valid),
    .o_data  (rdata)
  );

endmodule

// File: tb/tb_bank_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bank_access_ctrl
//   Bench for bank_access_ctrl with a behavioural Bank (registered read,
//   one cycle latency) and a reference memory / open-row model.
// ---------------------------------------------------------------------------
module tb_bank_access_ctrl;

  localparam int DW   = 4;
  localparam int CW   = 10;
  localparam int RW   = 5;
  localparam int BW   = 4;
  localparam int TRCD = 3;
  localparam int TRP  = 3;
  localparam int RDL  = 1;
  localparam int NCOL = 1 << CW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_wr = 1'b0;
  logic [RW-1:0] req_row = '0;
  logic [CW-1:0] req_col = '0;
  logic [BW-1:0] req_len = '0;
  logic          wdata_valid = 1'b0;
  logic          wdata_ready;
  logic [DW-1:0] wdata = '0;
  logic          rdata_valid;
  logic [DW-1:0] rdata;
  logic          rd_o_wr;
  logic [RW-1:0] row;
  logic [CW-1:0] column;
  logic [DW-1:0] dqin;
  logic [DW-1:0] dqout = '0;

  always #5 clk = ~clk;

  bank_access_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wr      (req_wr),
    .req_row     (req_row),
    .req_col     (req_col),
    .req_len     (req_len),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .wdata       (wdata),
    .rdata_valid (rdata_valid),
    .rdata       (rdata),
    .rd_o_wr     (rd_o_wr),
    .row         (row),
    .column      (column),
    .dqin        (dqin),
    .dqout       (dqout)
  );

  // Behavioural Bank: write on rd_o_wr, registered read every cycle
  logic [DW-1:0] bank_mem [0:(1<<(RW+CW))-1] = '{default: '0};
  always @(posedge clk) begin
    if (rd_o_wr) bank_mem[{row, column}] <= dqin;
    dqout <= bank_mem[{row, column}];
  end

  // Reference model
  logic [DW-1:0] ref_mem [0:(1<<(RW+CW))-1] = '{default: '0};
  bit mdl_open = 1'b0;
  int mdl_row  = 0;
  int exp_col  = 0;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete burst, checked cycle by cycle. Cycle 0 presents the
  // request; beat i is accepted in cycle d[i] and appears on the pins in
  // cycle d[i]+1. Writes may stall for stall_len cycles after beat
  // stall_after (negative = no stall).
  task automatic run_burst(input bit wr, input int rrow, input int rcol, input int rlen,
                           input int stall_after, input int stall_len, input string tag);
    int lat, last_dec, end_cyc, iss, wbeat, ridx;
    int d [16];
    logic [DW-1:0] beats [16];
    logic [DW-1:0] rexp  [16];
    lat = 2;
    if (!mdl_open)            lat += TRCD;
    else if (mdl_row != rrow) lat += TRP + TRCD;
    for (int i = 0; i <= rlen; i++) begin
      d[i]     = lat - 1 + i + ((wr && stall_after >= 0 && i > stall_after) ? stall_len : 0);
      beats[i] = DW'($urandom);
      rexp[i]  = ref_mem[rrow * NCOL + (rcol + i) % NCOL];
    end
    last_dec = d[rlen];
    end_cyc  = wr ? last_dec + 2 : last_dec + 2 + RDL;

    @(negedge clk);
    req_valid = 1'b1;
    req_wr    = wr;
    req_row   = RW'(rrow);
    req_col   = CW'(rcol);
    req_len   = BW'(rlen);
    chk({tag, ".req_ready_c0"}, req_ready, 1);

    for (int n = 1; n <= end_cyc; n++) begin
      @(negedge clk);
      req_valid = 1'b0;
      iss = -1; wbeat = -1;
      for (int i = 0; i <= rlen; i++) begin
        if (d[i] + 1 == n) iss = i;
        if (d[i] == n)     wbeat = i;
      end
      if (wr && wbeat >= 0) begin
        wdata_valid = 1'b1;
        wdata       = beats[wbeat];
      end else begin
        wdata_valid = 1'b0;
        wdata       = DW'($urandom);
      end
      if (iss >= 0) begin
        exp_col = (rcol + iss) % NCOL;
        chk({tag, ".row"}, row, rrow);
      end
      chk({tag, ".rd_o_wr"}, rd_o_wr, (wr && iss >= 0) ? 1 : 0);
      chk({tag, ".dqin"}, dqin, (wr && iss >= 0) ? beats[iss] : 0);
      chk({tag, ".column"}, column, exp_col);
      chk({tag, ".wdata_ready"}, wdata_ready, (wr && n >= lat - 1 && n <= last_dec) ? 1 : 0);
      chk({tag, ".req_ready"}, req_ready, (n > last_dec) ? 1 : 0);
      ridx = n - lat - RDL;
      if (!wr && ridx >= 0 && ridx <= rlen) begin
        chk({tag, ".rdata_valid"}, rdata_valid, 1);
        chk({tag, ".rdata"}, rdata, rexp[ridx]);
      end else begin
        chk({tag, ".rdata_valid"}, rdata_valid, 0);
        chk({tag, ".rdata"}, rdata, 0);
      end
    end

    if (wr)
      for (int i = 0; i <= rlen; i++) ref_mem[rrow * NCOL + (rcol + i) % NCOL] = beats[i];
    mdl_open = 1'b1;
    mdl_row  = rrow;
    $display("txn %s wr=%0d row=%0d col=%0d len=%0d lat=%0d cycles=%0d",
             tag, wr, rrow, rcol, rlen, lat, end_cyc);
  endtask

  initial begin
    int lat6, rwr, rrow, rcol, rlen, sa, sl;

    // Reset behaviour
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.req_ready", req_ready, 0);
    chk("rst.wdata_ready", wdata_ready, 0);
    chk("rst.rdata_valid", rdata_valid, 0);
    chk("rst.rdata", rdata, 0);
    chk("rst.rd_o_wr", rd_o_wr, 0);
    chk("rst.row", row, 0);
    chk("rst.column", column, 0);
    chk("rst.dqin", dqin, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle.req_ready", req_ready, 1);
    $display("txn reset done");

    // Directed scenarios
    run_burst(1'b1, 1, 0,    7, -1, 0, "s1_wr_act");
    run_burst(1'b0, 1, 0,    7, -1, 0, "s2_rd_hit");
    run_burst(1'b0, 2, 4,    0, -1, 0, "s3_rd_pre");
    run_burst(1'b1, 2, 1022, 3, -1, 0, "s4_wr_wrap");
    run_burst(1'b0, 2, 1022, 3, -1, 0, "s4_rd_wrap");
    run_burst(1'b1, 2, 100,  3,  1, 2, "s5_wr_stall");
    run_burst(1'b0, 2, 100,  3, -1, 0, "s5_rd_back");

    // Reset during a read burst, at the cycle beat 3 is on the pins
    lat6 = 2;
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0;
    req_row = RW'(2); req_col = CW'(100); req_len = BW'(7);
    for (int n = 1; n <= lat6 + 3; n++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    chk("s6.column_beat3", column, 103);
    rst = 1'b1;
    @(negedge clk);
    chk("s6.rd_o_wr", rd_o_wr, 0);
    chk("s6.row", row, 0);
    chk("s6.column", column, 0);
    chk("s6.rdata_valid", rdata_valid, 0);
    chk("s6.req_ready", req_ready, 0);
    rst = 1'b0;
    mdl_open = 1'b0;
    exp_col  = 0;
    $display("txn s6_rst_mid_read row=2 col=100 len=7");
    run_burst(1'b0, 2, 100, 3, -1, 0, "s6_rd_after_rst");

    // Randomized bursts over a few rows
    for (int t = 0; t < 12; t++) begin
      rwr  = int'($urandom_range(0, 1));
      rrow = int'($urandom_range(0, 3));
      rcol = int'($urandom_range(0, NCOL - 1));
      rlen = int'($urandom_range(0, 15));
      sa   = -1;
      sl   = 0;
      if (rwr == 1 && rlen > 0 && $urandom_range(0, 1) == 1) begin
        sa = int'($urandom_range(0, rlen - 1));
        sl = int'($urandom_range(1, 3));
      end
      run_burst(rwr[0], rrow, rcol, rlen, sa, sl, $sformatf("rnd%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
